instr_loader: RTL

Program loader that writes instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words, first byte into bits [31:24]. Each word is written to consecutive word-aligned byte addresses of the instruction memory through a one-cycle write strobe. The loader sits between the host/testbench byte source and the instruction memory's write port, and signals `done` so the core can be released from reset.

---
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream handshake between a host byte source and the loader.
// master: byte_in/byte_valid/byte_last out, byte_ready in; slave: the reverse.
interface instr_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses of instruction memory.
// Ports: clk, rst_n (async low), start pulse, bs (byte stream slave),
// mem_we/mem_addr/mem_wdata write port, busy/done/error status and
// word_count (program words written, fill words excluded).
// Build option LOADER_NOP_FILL_EN: after the last program word, pad the
// rest of memory with 32'h00000000 (NOP) before raising done.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_loader_if.slave     bs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef LOADER_NOP_FILL_EN
  localparam logic [2:0] S_FILL  = 3'd4;
  localparam logic [ADDR_W-1:0] TOP = ~ADDR_W'(3);
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [1:0]        idx;
  logic [31:0]       word;
  logic              last_seen;
  logic              wrap;
  logic              accept;

  assign addr_nxt = addr + ADDR_W'(4);
  assign wrap     = (addr_nxt == '0);
  assign accept   = bs.byte_valid && (state == S_RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      idx        <= '0;
      word       <= '0;
      last_seen  <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RECV;
            addr       <= '0;
            idx        <= '0;
            word       <= '0;
            last_seen  <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
          end
        end
        S_RECV: begin
          if (accept) begin
            unique case (idx)
              2'd0: word[31:24] <= bs.byte_in;
              2'd1: word[23:16] <= bs.byte_in;
              2'd2: word[15:8]  <= bs.byte_in;
              2'd3: word[7:0]   <= bs.byte_in;
            endcase
            idx <= idx + 2'd1;
            if (idx == 2'd3 || bs.byte_last) begin
              state     <= S_WRITE;
              last_seen <= bs.byte_last;
            end
          end
        end
        S_WRITE: begin
          addr       <= addr_nxt;
          word_count <= word_count + (ADDR_W-1)'(1);
          idx        <= '0;
          word       <= '0;
          if (last_seen) begin
`ifdef LOADER_NOP_FILL_EN
            state <= wrap ? S_DONE : S_FILL;
`else
            state <= S_DONE;
`endif
          end else if (wrap) begin
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_RECV;
          end
        end
`ifdef LOADER_NOP_FILL_EN
        // word is already cleared, so mem_wdata carries the NOP
        S_FILL: begin
          addr <= addr_nxt;
          if (addr == TOP) state <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      (state == S_RECV):  busy = 1'b1;
      (state == S_WRITE): begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
`ifdef LOADER_NOP_FILL_EN
      (state == S_FILL): begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
`endif
      (state == S_DONE):  done = 1'b1;
      default: ;
    endcase
  end

  assign bs.byte_ready = (state == S_RECV);
  assign mem_addr      = addr;
  assign mem_wdata     = word;

endmodule
